// File: rtl/b_st_fifo_pkg.sv
// Shared definitions for the b_st_fifo slice: record types, default sizing
// constants and the occupancy type used by b_st_fifo and its storage.
package b_st_fifo_pkg;

    localparam int B_ST_FIFO_B_SIZE = 9;
    localparam int B_ST_FIFO_DEPTH  = 8;
    localparam int B_ST_FIFO_AFULL  = 6;

    // Payload carried through the FIFO.
    typedef logic [B_ST_FIFO_B_SIZE-1:0] bSizeT;

    // Record wrapper; a single field, so it is bit-identical to bSizeT.
    typedef struct packed {
        bSizeT bAnother;
    } bSt;

    // Occupancy 0..DEPTH inclusive, hence one bit wider than a pointer.
    typedef logic [$clog2(B_ST_FIFO_DEPTH+1)-1:0] bStFifoCntT;

endpackage

// File: rtl/b_st_fifo_mem.sv
// Storage array for b_st_fifo: DEPTH x WIDTH, one synchronous write port
// and one asynchronous (combinational) read port.
module b_st_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write one entry per cycle.
    // NOTE: the array has no reset; entries are only read once written, so
    // resetting them would add a reset fan-out and block RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/b_st_fifo.sv
// b_st_fifo: synchronous valid/ready FIFO with registered count,
// almost_full and a sticky overflow flag.
// Optional build macro B_ST_FIFO_BYPASS_EN: when empty, an incoming push is
// presented on pop_* in the same cycle and is not stored if it is popped.
module b_st_fifo
    import b_st_fifo_pkg::*;
#(
    parameter int B_SIZE    = B_ST_FIFO_B_SIZE,
    parameter int DEPTH     = B_ST_FIFO_DEPTH,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [B_SIZE-1:0]          push_data,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [B_SIZE-1:0]          pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              afull_q, afull_d;
    logic              ovf_q, ovf_d;

    logic              full, empty;
    logic              push_fire, pop_fire, bypass_take;
    logic              do_push, do_pop;
    logic [B_SIZE-1:0] mem_rdata;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign push_ready = !full;

`ifdef B_ST_FIFO_BYPASS_EN
    // Empty FIFO forwards the incoming word; if it is consumed right away
    // the transfer goes straight through and nothing is stored.
    assign bypass_take = empty && push_valid && pop_ready;
    assign pop_valid   = !empty || push_valid;
    assign pop_data    = empty ? push_data : mem_rdata;
`else
    assign bypass_take = 1'b0;
    assign pop_valid   = !empty;
    assign pop_data    = mem_rdata;
`endif

    assign push_fire = push_valid && push_ready;
    assign pop_fire  = pop_valid && pop_ready;
    // A flush discards whatever handshake happens in the same cycle.
    assign do_push   = push_fire && !bypass_take && !flush;
    assign do_pop    = pop_fire && !bypass_take && !flush;

    // Next-state for pointers, occupancy and status flags.
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q || (push_valid && full);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        afull_d = (count_d >= CNT_W'(AFULL_LVL));
    end

    // State registers with asynchronous active-low reset.
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of statement order or of other always_ff blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    assign count        = count_q;
    assign almost_full  = afull_q;
    assign overflow_err = ovf_q;

    b_st_fifo_mem #(
        .WIDTH (B_SIZE),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_push),
        .wr_addr (wr_ptr_q),
        .wr_data (push_data),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rdata)
    );

endmodule

// File: tb/tb_b_st_fifo.sv
// Bench for b_st_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_b_st_fifo;

    localparam int B_SIZE    = 9;
    localparam int DEPTH     = 8;
    localparam int AFULL_LVL = 6;
    localparam int CNT_W     = $clog2(DEPTH + 1);
`ifdef B_ST_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              flush      = 1'b0;
    logic              push_valid = 1'b0;
    logic              pop_ready  = 1'b0;
    logic [B_SIZE-1:0] push_data  = '0;
    logic              push_ready;
    logic              pop_valid;
    logic [B_SIZE-1:0] pop_data;
    logic [CNT_W-1:0]  count;
    logic              almost_full;
    logic              overflow_err;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    logic [B_SIZE-1:0] model_q [$];
    bit                model_ovf = 1'b0;

    b_st_fifo #(
        .B_SIZE    (B_SIZE),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_data    (push_data),
        .pop_valid    (pop_valid),
        .pop_ready    (pop_ready),
        .pop_data     (pop_data),
        .count        (count),
        .almost_full  (almost_full),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue advanced on each rising edge.
    always @(posedge clk) begin : model_proc
        int sz;
        if (rst_n) begin
            sz = model_q.size();
            if (push_valid && sz == DEPTH) model_ovf = 1'b1;
            if (flush) begin
                model_q.delete();
            end else if (!(BYP && sz == 0 && push_valid && pop_ready)) begin
                if (pop_ready && sz != 0) void'(model_q.pop_front());
                if (push_valid && sz != DEPTH) model_q.push_back(push_data);
            end
        end
    end

    always @(negedge rst_n) begin
        model_q.delete();
        model_ovf = 1'b0;
    end

    // Per-cycle comparison on the falling edge, inputs already set for the next edge.
    always @(negedge clk) begin : cmp_proc
        int                sz;
        bit                exp_pv;
        logic [B_SIZE-1:0] exp_pd;
        if (cmp_en && rst_n) begin
            sz     = model_q.size();
            exp_pv = (sz != 0) || (BYP && push_valid);
            exp_pd = (sz != 0) ? model_q[0] : push_data;
            check("count", 32'(count), 32'(sz));
            check("push_ready", 32'(push_ready), 32'(sz != DEPTH));
            check("pop_valid", 32'(pop_valid), 32'(exp_pv));
            check("almost_full", 32'(almost_full), 32'(sz >= AFULL_LVL));
            check("overflow_err", 32'(overflow_err), 32'(model_ovf));
            if (exp_pv) check("pop_data", 32'(pop_data), 32'(exp_pd));
        end
    end

    task automatic step(input bit pv, input logic [B_SIZE-1:0] pd, input bit pr, input bit fl);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        flush      = fl;
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state while rst_n is held low.
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_push_ready", 32'(push_ready), 32'd1);
        check("rst_pop_valid", 32'(pop_valid), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_ovf", 32'(overflow_err), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;

        // Fill 0x001..0x008 with no pops.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, B_SIZE'(i), 1'b0, 1'b0);
            check("fill_count", 32'(count), 32'(i));
            check("fill_afull", 32'(almost_full), 32'(i >= 6));
        end
        check("full_push_ready", 32'(push_ready), 32'd0);

        // Push while full: refused, sticky overflow.
        step(1'b1, 9'h0FF, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow_err), 32'd1);
        check("ovf_count", 32'(count), 32'd8);

        // Drain in order.
        for (int i = 1; i <= 8; i++) begin
            check("drain_data", 32'(pop_data), 32'(i));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("drain_count", 32'(count), 32'd0);
        check("drain_pop_valid", 32'(pop_valid), 32'd0);
        check("ovf_sticky", 32'(overflow_err), 32'd1);

        // Simultaneous push/pop at count 3 across pointer wrap.
        for (int i = 0; i < 3; i++) step(1'b1, B_SIZE'(16 + i), 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            check("pp_data", 32'(pop_data), 32'(16 + k));
            step(1'b1, B_SIZE'(19 + k), 1'b1, 1'b0);
            check("pp_count", 32'(count), 32'd3);
        end
        for (int i = 0; i < 3; i++) begin
            check("pp_tail_data", 32'(pop_data), 32'(36 + i));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("pp_empty", 32'(count), 32'd0);

        // Flush at count 5 with a concurrent push of 0x1AA.
        for (int i = 0; i < 5; i++) step(1'b1, B_SIZE'(32 + i), 1'b0, 1'b0);
        check("pre_flush_count", 32'(count), 32'd5);
        step(1'b1, 9'h1AA, 1'b0, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_pop_valid", 32'(pop_valid), 32'd0);
        check("flush_afull", 32'(almost_full), 32'd0);
        step(1'b1, 9'h030, 1'b0, 1'b0);
        check("post_flush_data", 32'(pop_data), 32'h030);
        step(1'b0, '0, 1'b1, 1'b0);
        check("post_flush_count", 32'(count), 32'd0);

        // Mid-stream reset at count 4, low for half a cycle.
        for (int i = 0; i < 4; i++) step(1'b1, B_SIZE'(64 + i), 1'b0, 1'b0);
        check("pre_rst_count", 32'(count), 32'd4);
        rst_n = 1'b0;
        #1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_pop_valid", 32'(pop_valid), 32'd0);
        check("midrst_push_ready", 32'(push_ready), 32'd1);
        check("midrst_afull", 32'(almost_full), 32'd0);
        check("midrst_ovf", 32'(overflow_err), 32'd0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_valid = 1'b1;
        push_data  = 9'h055;
        #1;
        check("lat_pre_valid", 32'(pop_valid), 32'(BYP));
        step(1'b1, 9'h055, 1'b0, 1'b0);
        check("lat_post_valid", 32'(pop_valid), 32'd1);
        check("lat_post_data", 32'(pop_data), 32'h055);
        step(1'b0, '0, 1'b1, 1'b0);
        check("lat_empty", 32'(count), 32'd0);

        // Push 0x155 into an empty FIFO with pop_ready high.
        push_valid = 1'b1;
        push_data  = 9'h155;
        pop_ready  = 1'b1;
        #1;
`ifdef B_ST_FIFO_BYPASS_EN
        check("byp_same_valid", 32'(pop_valid), 32'd1);
        check("byp_same_data", 32'(pop_data), 32'h155);
        step(1'b1, 9'h155, 1'b1, 1'b0);
        check("byp_count", 32'(count), 32'd0);
        check("byp_after_valid", 32'(pop_valid), 32'd0);
`else
        check("nobyp_same_valid", 32'(pop_valid), 32'd0);
        step(1'b1, 9'h155, 1'b1, 1'b0);
        check("nobyp_next_valid", 32'(pop_valid), 32'd1);
        check("nobyp_next_data", 32'(pop_data), 32'h155);
        check("nobyp_count", 32'(count), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("nobyp_empty", 32'(count), 32'd0);
`endif

        step(1'b0, '0, 1'b0, 1'b0);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
